cmos_pixel_filter: RTL
======================

// Module: cmos_pixel_filter
// PURPOSE
//  Pixel-processing stage between cmos_capture and vga_config in the OV7670 camera path.
//  Takes the RGB565 pixel stream with sop/eop markers and outputs RGB565 in one of three forms:
//  unmodified, grayscale, or binarised. Output uses the same vld/sop/eop protocol.
//  Also checks frame integrity (pixel count, sop/eop ordering) and passes only frames that start cleanly.
// PARAMETERS
//  H_PIX    640  active pixels per line
//  V_LINES  480  active lines per frame; FRAME_PIX = H_PIX*V_LINES
// PORTS
//  clk        in   1   pixel clock (same domain as cmos_capture output)
//  rst        in   1   synchronous, active-high reset
//  en         in   1   1 = accept frames; 0 = finish current frame, then drop
//  mode       in   2   0 bypass, 1 gray, 2 binary, 3 = bypass
//  threshold  in   8   binary-mode luma threshold
//  din        in   16  RGB565 {R5,G6,B5}
//  din_vld    in   1   pixel valid
//  din_sop    in   1   first pixel of frame (qualified by din_vld)
//  din_eop    in   1   last pixel of frame (qualified by din_vld)
//  dout       out  16  processed RGB565
//  dout_vld   out  1   output valid
//  dout_sop   out  1   output first pixel
//  dout_eop   out  1   output last pixel
//  frame_err  out  1   1-cycle pulse on a malformed frame
//  frame_cnt  out  16  count of good frames, wraps at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0; FSM in WAIT_SOP; pipeline valids cleared; latched mode = 0.
//  Latency: fixed at 3 cycles from din_vld to dout_vld, in every mode. sop/eop are delayed to match.
//  No backpressure: one pixel in per cycle, one out per cycle.
//  FSM states:
//   WAIT_SOP: drop every pixel until din_vld&din_sop. On that pixel:
//    - if en=1, latch mode/threshold, clear pix_cnt, go to IN_FRAME;
//    - otherwise stay.
//   IN_FRAME: forward each vld pixel and increment pix_cnt (17+ bits wide).
//    - eop with pix_cnt==FRAME_PIX-1: good frame; frame_cnt++, go to WAIT_SOP.
//    - eop with any other count: frame_err pulse, frame_cnt unchanged, go to WAIT_SOP.
//    - sop before eop: frame_err pulse. The new sop restarts the frame (relatch mode, pix_cnt=0).
//      The first pixel of the new frame carries dout_sop. No eop is ever synthesised.
//    - pixel at pix_cnt==FRAME_PIX with no eop: frame_err pulse; drop the rest of the frame in WAIT_SOP.
//  sop and eop on the same beat: legal only when FRAME_PIX==1; otherwise treated as an error.
//  mode/threshold change mid-frame: ignored until the next accepted sop.
//  en deasserted mid-frame: the current frame completes normally.
//  frame_err fires at most once per beat. It is aligned to input timing, not output timing.
//  Datapath (arithmetic unsigned):
//   S1: expand to 8 bit: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]};
//       form products 77*R8, 150*G8, 29*B8 (16 bit each).
//   S2: sum (17 bit), Y = sum[15:8]. Weights total 256, so Y never exceeds 255.
//   S3: output mux:
//       bypass -> din unchanged;
//       gray -> {Y[7:3],Y[7:2],Y[7:3]};
//       binary -> (Y>=threshold) ? 16'hFFFF : 16'h0000.
//  Reset mid-frame: pipeline flushes with no partial output; frame_cnt returns to 0.
// STRUCTURE
//  Shared package/header: MODE_BYPASS/MODE_GRAY/MODE_BIN encodings, luma weights 77/150/29,
//   FSM state encodings.
//  One sub-module: rgb565_to_luma, the 2-stage pipelined S1-S2 luma calculation
//   (clk, rst, rgb in, y out).
//  Top of this block holds the FSM, pix_cnt, delay line for vld/sop/eop/raw pixel, and the S3 mux.
// TESTING (bench uses H_PIX=4, V_LINES=2 -> FRAME_PIX=8)
//  1. mode=1, 8-pixel frame of 16'hF800:
//     -> dout=16'h4A69 (Y=76) for all 8 pixels; sop on the 1st, eop on the 8th;
//        latency 3; frame_cnt=1.
//  2. mode=2, threshold=128, pixels F800,FFFF,0000,07E0:
//     -> 0000,FFFF,0000,FFFF (Y=76,255,0,149).
//  3. mode=0, pixels 16'h1234.. -> identical dout 3 cycles later.
//     mode switched to 1 mid-frame -> still bypass until the next sop.
//  4. Frame with eop on pixel 6 -> frame_err pulse, frame_cnt unchanged.
//     Next good frame -> frame_cnt increments.
//  5. sop on pixel 5 of a frame -> frame_err; the new frame is output with dout_sop.
//     Stream with no sop -> no dout_vld at all.
//  6. en=0 during frame 1 -> frame 1 completes; frame 2 dropped.
//     rst mid-frame -> all outputs 0 next cycle; resumes only at the next sop.

Source files
------------

// File: rtl/cmos_pixel_filter_pkg.sv
// Shared types and constants for the camera pixel filter.
// Mode encodings, luma weights, FSM states and the pipeline beat bundle.
package cmos_pixel_filter_pkg;

   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_GRAY   = 2'd1;
   localparam logic [1:0] MODE_BIN    = 2'd2;

   localparam logic [7:0] W_R = 8'd77;
   localparam logic [7:0] W_G = 8'd150;
   localparam logic [7:0] W_B = 8'd29;

   typedef enum logic {
      WAIT_SOP = 1'b0,
      IN_FRAME = 1'b1
   } state_t;

   typedef struct packed {
      logic        vld;
      logic        sop;
      logic        eop;
      logic [15:0] pix;
      logic [1:0]  mode;
      logic [7:0]  thr;
   } beat_t;

   function automatic logic [15:0] gray565(input logic [7:0] y);
      return {y[7:3], y[7:2], y[7:3]};
   endfunction

endpackage

// File: rtl/cmos_pixel_filter_if.sv
// RGB565 pixel stream with frame markers.
// No backpressure: one beat per cycle whenever vld is high.
interface cmos_pixel_filter_if;
   logic [15:0] data;
   logic        vld;
   logic        sop;
   logic        eop;

   modport master (output data, vld, sop, eop);
   modport slave  (input  data, vld, sop, eop);
endinterface

// File: rtl/cmos_pixel_filter_rgb565_to_luma.sv
// Two-stage luma: expand RGB565 to 8 bit and weight (S1), sum and scale (S2).
// Weights total 256, so the scaled sum always fits in 8 bits.
module cmos_pixel_filter_rgb565_to_luma
   import cmos_pixel_filter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] rgb,
   output logic [7:0]  y
);

   logic [7:0]  r8, g8, b8;
   logic [15:0] pr, pg, pb;
   logic [16:0] sum;

   assign r8  = {rgb[15:11], rgb[15:13]};
   assign g8  = {rgb[10:5], rgb[10:9]};
   assign b8  = {rgb[4:0], rgb[4:2]};
   assign sum = 17'(pr) + 17'(pg) + 17'(pb);

   always_ff @(posedge clk) begin
      if (rst) begin
         pr <= '0;
         pg <= '0;
         pb <= '0;
         y  <= '0;
      end else begin
         pr <= 16'(W_R) * 16'(r8);
         pg <= 16'(W_G) * 16'(g8);
         pb <= 16'(W_B) * 16'(b8);
         y  <= 8'(sum >> 8);
      end
   end

endmodule

// File: rtl/cmos_pixel_filter.sv
// Frame-checking pixel filter: bypass, grayscale or binarised RGB565.
// Fixed 3-cycle latency; only frames that start with an accepted sop pass.
module cmos_pixel_filter
   import cmos_pixel_filter_pkg::*;
#(
   parameter int H_PIX   = 640,
   parameter int V_LINES = 480
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [7:0]          threshold,
   cmos_pixel_filter_if.slave  din,
   cmos_pixel_filter_if.master dout,
   output logic                frame_err,
   output logic [15:0]         frame_cnt
);

   localparam int FRAME_PIX = H_PIX * V_LINES;
   localparam int CW_MIN    = $clog2(FRAME_PIX + 1);
   localparam int CNT_W     = (CW_MIN > 17) ? CW_MIN : 17;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIX - 1);
   localparam logic [CNT_W-1:0] OVER = CNT_W'(FRAME_PIX);

   state_t           state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [1:0]       mode_q, cur_mode;
   logic [7:0]       thr_q, cur_thr;
   logic             fwd, latch, good, err;
   beat_t            s1, s2;
   logic [7:0]       y;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT_SOP;
         cnt       <= '0;
         mode_q    <= MODE_BYPASS;
         thr_q     <= '0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= nxt_state;
         cnt       <= nxt_cnt;
         frame_err <= err;
         if (good)
            frame_cnt <= frame_cnt + 16'd1;
         if (latch) begin
            mode_q <= mode;
            thr_q  <= threshold;
         end
      end
   end

   // cnt holds the index of the next pixel expected in the frame
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      fwd       = 1'b0;
      latch     = 1'b0;
      good      = 1'b0;
      err       = 1'b0;
      if (din.vld && din.sop) begin
         err       = (state == IN_FRAME);
         nxt_state = WAIT_SOP;
         if (en) begin
            fwd       = 1'b1;
            latch     = 1'b1;
            nxt_cnt   = CNT_W'(1);
            nxt_state = IN_FRAME;
            if (din.eop) begin
               nxt_state = WAIT_SOP;
               if (FRAME_PIX == 1)
                  good = 1'b1;
               else
                  err = 1'b1;
            end
         end
      end else if (din.vld) begin
         unique case (state)
            WAIT_SOP: ;
            IN_FRAME: begin
               if (cnt == OVER) begin
                  err       = 1'b1;
                  nxt_state = WAIT_SOP;
               end else begin
                  fwd     = 1'b1;
                  nxt_cnt = cnt + CNT_W'(1);
                  if (din.eop) begin
                     nxt_state = WAIT_SOP;
                     good      = (cnt == LAST);
                     err       = (cnt != LAST);
                  end
               end
            end
            default: nxt_state = WAIT_SOP;
         endcase
      end
   end

   // A restarting sop uses the new settings on its own pixel
   assign cur_mode = latch ? mode : mode_q;
   assign cur_thr  = latch ? threshold : thr_q;

   cmos_pixel_filter_rgb565_to_luma u_luma (
      .clk (clk),
      .rst (rst),
      .rgb (din.data),
      .y   (y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= '0;
         s2        <= '0;
         dout.vld  <= 1'b0;
         dout.sop  <= 1'b0;
         dout.eop  <= 1'b0;
         dout.data <= '0;
      end else begin
         s1.vld    <= fwd;
         s1.sop    <= fwd & din.sop;
         s1.eop    <= fwd & din.eop;
         s1.pix    <= din.data;
         s1.mode   <= cur_mode;
         s1.thr    <= cur_thr;
         s2        <= s1;
         dout.vld  <= s2.vld;
         dout.sop  <= s2.sop;
         dout.eop  <= s2.eop;
         unique case (1'b1)
            (s2.mode == MODE_GRAY): dout.data <= gray565(y);
            (s2.mode == MODE_BIN):
               dout.data <= (y >= s2.thr) ? 16'hFFFF : 16'h0000;
            default: dout.data <= s2.pix;
         endcase
      end
   end

endmodule
